parity_frame_ctrl: RTL
======================

Name: parity_frame_ctrl

Overview:
Sequencer that feeds a serial parity path. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per accepted serial beat. It tracks running parity and appends an even/odd parity bit as the final beat of the frame. It sits between a parallel producer and the serial line/parity checker, and reports the computed parity with a completion pulse.

Parameters:
DATA_W, 8, data bits per frame (>=2).
CNT_W, $clog2(DATA_W), bit-counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer has a word.
in_ready  output  1  controller can accept a word.
in_data  input  DATA_W  parallel word.
odd_sel  input  1  parity mode, sampled at accept: 0=even, 1=odd.
abort  input  1  synchronous frame abort.
ser_ready  input  1  downstream accepts the current serial beat.
ser_valid  output  1  ser_out is valid this cycle.
ser_out  output  1  serial data or parity bit.
ser_last  output  1  current beat is the parity bit.
par_out  output  1  parity bit of the last completed frame.
done  output  1  one-cycle pulse when a frame completes.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift reg=0, count=0, running parity=0, odd_q=0. All outputs are 0 except in_ready=1.
- States: IDLE, SHIFT, PARITY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: shreg<=in_data, odd_q<=odd_sel, count<=0, acc<=0, go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_out=shreg[0], ser_last=0.
  - A beat completes only when ser_valid && ser_ready. On completion: acc<=acc^shreg[0], shreg>>=1, count++.
  - When the beat with count==DATA_W-1 completes, go to PARITY.
  - ser_ready=0 holds shreg, count and acc unchanged. ser_out stays stable while stalled.
- PARITY:
  - ser_valid=1, ser_last=1, ser_out=acc^odd_q.
  - When ser_ready is high: par_out<=acc^odd_q, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency, ser_ready tied high, accept at edge k:
  - data beats occupy cycles k+1..k+DATA_W;
  - the parity beat is cycle k+DATA_W+1;
  - done is cycle k+DATA_W+2;
  - in_ready rises at k+DATA_W+3.
- Throughput: one frame per DATA_W+3 cycles.
- in_ready=0 outside IDLE. in_valid while busy is ignored; the producer must hold it.
- abort:
  - In SHIFT or PARITY: go to IDLE next cycle. No done pulse; par_out is unchanged.
  - In IDLE: blocks acceptance that cycle (abort has priority over accept).
  - In DONE: ignored; done still fires.
- par_out holds its value until the next completed frame.
- Reset mid-frame: immediate return to reset values, no done pulse.
- odd_sel changes after accept do not affect the current frame.

Decomposition:
- Shared package parity_pkg:
  - state enum {IDLE, SHIFT, PARITY, DONE};
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
- Sub-module parity_accum holds the running XOR bit. Inputs: clk, rst_n, clr, en, d. Output: p. It clears on accept and toggles on each completed data beat; the controller instantiates it once.

Test Plan:
- Even, no stall: in_data=8'hA5, odd_sel=0, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1, then parity 0 with ser_last=1. done at k+10, par_out=0, in_ready back at k+11.
- Odd mode: in_data=8'h07, odd_sel=1 -> data 1,1,1,0,0,0,0,0, then parity bit 0 (3 ones ^1). par_out=0. Same data with odd_sel=0 -> parity 1.
- Backpressure: 8'hA5 with ser_ready low for 3 cycles during beat 2 and 2 cycles during the parity beat -> ser_out stable while stalled, bit sequence unchanged, done delayed by 5 cycles.
- Abort: abort on beat 4 of 8'hFF -> IDLE next cycle, no done, par_out keeps its previous value. A subsequent 8'h01 frame completes with parity 1 (even).
- Busy ignore: in_valid with 8'h3C held during an 8'h01 frame -> 8'h3C is not accepted until in_ready=1, then sent correctly with even parity 0.
- Async reset: rst_n low mid-SHIFT for 1 cycle -> outputs return to reset values immediately (in_ready=1, busy=0, ser_valid=0), with no done pulse.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame sequencer.
//   state_t  : controller states (IDLE, SHIFT, PARITY, DONE)
//   PAR_EVEN : odd_sel value that selects even parity
//   PAR_ODD  : odd_sel value that selects odd parity
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Running-parity accumulator: a single XOR bit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears p
//   clr   : synchronous clear (start of a new frame), wins over en
//   en    : fold d into the running parity this cycle
//   d     : data bit to fold in
//   p     : current running parity (XOR of all folded bits)
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 1'b0;
        end else if (clr) begin
            p <= 1'b0;
        end else if (en) begin
            p <= p ^ d;
        end
    end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Parallel-to-serial frame sequencer with appended parity bit.
// A word accepted on the in_valid/in_ready handshake is shifted out LSB-first,
// one bit per completed serial beat, followed by a parity beat (ser_last=1).
//
// Handshake rule (both interfaces): a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload stable until
// then, and valid never depends on ready.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : parallel word handshake; in_ready only in IDLE
//   in_data [DATA_W]      : parallel word
//   odd_sel               : parity mode sampled at accept (0 even, 1 odd)
//   abort                 : synchronous frame abort
//   ser_valid/ser_ready   : serial beat handshake
//   ser_out               : data bit or parity bit
//   ser_last              : current beat is the parity bit
//   par_out               : parity of the last completed frame
//   done                  : one-cycle completion pulse
//   busy                  : state is not IDLE
//   dbg_state             : current FSM state, for observation
import parity_pkg::*;

module parity_frame_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_sel,
    input  logic              abort,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_out,
    output logic              ser_last,
    output logic              par_out,
    output logic              done,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  count;
    logic              odd_q;
    logic              par_q;
    logic              acc;

    // Abort has priority over both acceptance and a completing beat.
    logic accept;
    logic beat;
    assign accept = (state == IDLE)  && in_valid  && !abort;
    assign beat   = (state == SHIFT) && ser_ready && !abort;

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (beat),
        .d     (shreg[0]),
        .p     (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
            odd_q <= 1'b0;
            par_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= in_data;
                        odd_q <= odd_sel;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (ser_ready) begin
                        shreg <= shreg >> 1;
                        count <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (ser_ready) begin
                        par_q <= acc ^ odd_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // abort is deliberately ignored here: the frame is complete.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so they are stable for the whole
    // cycle and do not depend combinationally on ser_ready or abort.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ser_valid = (state == SHIFT) || (state == PARITY);
    assign ser_last  = (state == PARITY);
    assign ser_out   = (state == SHIFT)  ? shreg[0] :
                       (state == PARITY) ? (acc ^ odd_q) : 1'b0;
    assign done      = (state == DONE);
    assign par_out   = par_q;
    assign dbg_state = state;

endmodule
